mac_table_ctl: RTL

//  Sequencer for the bridge MAC address table. Arbitrates between lookup and learn requesters,

---
 rtl/mac_table_ctl_pkg.sv | 22 ++
 rtl/basic_hashfunc.sv | 23 ++
 rtl/mac_table_ctl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mac_table_ctl_pkg.sv
// Shared definitions for the MAC table sequencer: FSM encoding and table entry layout.
// Entry layout is {valid, mac, port} with port in the least significant bits.
package mac_table_ctl_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_CMP,
        S_WRITE,
        S_RESULT
    } state_t;

    localparam int ADDR_SZ  = 48;
    localparam int PORT_SZ  = 4;
    localparam int ENTRY_W  = 1 + ADDR_SZ + PORT_SZ;

    localparam int PORT_LSB = 0;
    localparam int MAC_LSB  = PORT_SZ;
    localparam int VLD_BIT  = PORT_SZ + ADDR_SZ;

endpackage

// File: rtl/basic_hashfunc.sv
// XOR fold of an input_sz-bit key into fsz-bit slices; the top slice is zero-padded.
module basic_hashfunc #(
    parameter int input_sz = 48,
    parameter int fsz      = 8
) (
    input  logic [input_sz-1:0] hf_in,
    output logic [fsz-1:0]      hf_out
);

    localparam int FOLDS = (input_sz + fsz - 1) / fsz;

    logic [FOLDS*fsz-1:0] padded;

    always_comb begin
        padded                 = '0;
        padded[input_sz-1:0]   = hf_in;
        hf_out                 = '0;
        for (int f = 0; f < FOLDS; f++) begin
            hf_out = hf_out ^ padded[f*fsz +: fsz];
        end
    end

endmodule

// File: rtl/mac_table_ctl.sv
// Bridge MAC table sequencer: round-robin lookup/learn arbitration, hashed single-port RAM
// access with 1-cycle read latency, lookup results on a srdy/drdy handshake, clear after reset.
module mac_table_ctl
    import mac_table_ctl_pkg::*;
#(
    parameter int addr_sz  = ADDR_SZ,
    parameter int port_sz  = PORT_SZ,
    parameter int table_sz = 1024,
    parameter int asz      = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        lu_srdy,
    output logic                        lu_drdy,
    input  logic [addr_sz-1:0]          lu_addr,
    input  logic                        ln_srdy,
    output logic                        ln_drdy,
    input  logic [addr_sz-1:0]          ln_addr,
    input  logic [port_sz-1:0]          ln_port,
    output logic                        res_srdy,
    input  logic                        res_drdy,
    output logic                        res_hit,
    output logic [port_sz-1:0]          res_port,
    output logic [asz-1:0]              tbl_addr,
    output logic                        tbl_rd_en,
    output logic                        tbl_wr_en,
    output logic [addr_sz+port_sz:0]    tbl_wr_data,
    input  logic [addr_sz+port_sz:0]    tbl_rd_data,
    output logic                        init_done
);

    localparam logic [asz-1:0] INIT_LAST = asz'(table_sz - 1);

    state_t               state, state_nxt;
    logic [asz-1:0]       init_cnt;
    logic [asz-1:0]       hash;
    logic                 rr_lu;
    logic                 pick_lu;
    logic                 accept;
    logic                 op_learn;
    logic [addr_sz-1:0]   mac_q;
    logic [port_sz-1:0]   port_q;
    logic                 rd_vld;
    logic [addr_sz-1:0]   rd_mac;
    logic [port_sz-1:0]   rd_port;
    logic                 hit;

    basic_hashfunc #(
        .input_sz (addr_sz),
        .fsz      (asz)
    ) u_hash (
        .hf_in  (mac_q),
        .hf_out (hash)
    );

    assign rd_vld  = tbl_rd_data[VLD_BIT];
    assign rd_mac  = tbl_rd_data[MAC_LSB +: addr_sz];
    assign rd_port = tbl_rd_data[PORT_LSB +: port_sz];
    assign hit     = rd_vld && (rd_mac == mac_q);

    // With no contention the single active requester wins; idle cycles keep the RR choice.
    always_comb begin
        pick_lu = rr_lu;
        if (lu_srdy && !ln_srdy) begin
            pick_lu = 1'b1;
        end else if (ln_srdy && !lu_srdy) begin
            pick_lu = 1'b0;
        end
    end

    assign lu_drdy = (state == S_IDLE) && pick_lu;
    assign ln_drdy = (state == S_IDLE) && !pick_lu;
    assign accept  = (lu_drdy && lu_srdy) || (ln_drdy && ln_srdy);

    always_comb begin
        state_nxt   = state;
        tbl_rd_en   = 1'b0;
        tbl_wr_en   = 1'b0;
        tbl_addr    = hash;
        tbl_wr_data = '0;
        res_srdy    = 1'b0;
        case (state)
            S_INIT: begin
                tbl_wr_en = 1'b1;
                tbl_addr  = init_cnt;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                tbl_rd_en = 1'b1;
                state_nxt = S_CMP;
            end
            S_CMP: begin
                if (!op_learn) begin
                    state_nxt = S_RESULT;
                end else if (hit && (rd_port == port_q)) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                tbl_wr_en   = 1'b1;
                tbl_wr_data = {1'b1, mac_q, port_q};
                state_nxt   = S_IDLE;
            end
            S_RESULT: begin
                res_srdy = 1'b1;
                if (res_drdy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            rr_lu     <= 1'b1;
            init_done <= 1'b0;
            res_hit   <= 1'b0;
            res_port  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == INIT_LAST) begin
                    init_done <= 1'b1;
                end
            end
            if (accept) begin
                rr_lu <= ln_drdy;
            end
            if ((state == S_CMP) && !op_learn) begin
                res_hit  <= hit;
                res_port <= hit ? rd_port : '0;
            end
        end
    end

    // Request payload is captured at accept and needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mac_q    <= lu_drdy ? lu_addr : ln_addr;
            port_q   <= ln_port;
            op_learn <= ln_drdy;
        end
    end

endmodule
